// File: rtl/lc3_ctrl_pkg.sv
// Shared opcode constants, instruction-class helpers and the memory FSM
// state type for the LC-3 pipeline controller.
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        MS_READ     = 2'd0,
        MS_IND_READ = 2'd1,
        MS_WRITE    = 2'd2,
        MS_IDLE     = 2'd3
    } mem_state_t;

    // Instructions whose result goes back to the register file from the ALU.
    function automatic logic is_alu(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LEA: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        logic r;
        case (op)
            OP_LD, OP_LDR, OP_LDI: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        logic r;
        case (op)
            OP_ST, OP_STR, OP_STI: r = 1'b1;
            default:               r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_ctl(input logic [3:0] op);
        logic r;
        case (op)
            OP_BR, OP_JMP: r = 1'b1;
            default:       r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions that read a base/source register from IR[8:6].
    function automatic logic uses_sr1(input logic [3:0] op);
        logic r;
        case (op)
            OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_STR, OP_JMP: r = 1'b1;
            default:                                        r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lc3_control_unit_if.sv
// control_in bus between the LC-3 datapath (status producer) and the
// pipeline controller (enable/select consumer).
interface lc3_control_unit_if;
    logic        completed_instr;
    logic        completed_data;
    logic [15:0] IR;
    logic [15:0] IR_EXEC;
    logic [15:0] Imem_dout;
    logic [2:0]  NZP;
    logic [2:0]  PSR;
    logic        enable_updatePC;
    logic        enable_fetch;
    logic        enable_decode;
    logic        enable_execute;
    logic        enable_writeback;
    logic        bypass_alu_1;
    logic        bypass_alu_2;
    logic        br_taken;
    logic [1:0]  mem_state;

    modport master (
        output completed_instr, completed_data, IR, IR_EXEC, Imem_dout, NZP, PSR,
        input  enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, bypass_alu_1, bypass_alu_2, br_taken, mem_state
    );

    modport slave (
        input  completed_instr, completed_data, IR, IR_EXEC, Imem_dout, NZP, PSR,
        output enable_updatePC, enable_fetch, enable_decode, enable_execute,
               enable_writeback, bypass_alu_1, bypass_alu_2, br_taken, mem_state
    );
endinterface

// File: rtl/lc3_mem_fsm.sv
// Data-memory sequencer: tracks direct reads, writes and the extra pointer
// fetch of indirect LDI/STI accesses.
module lc3_mem_fsm
    import lc3_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_execute,
    input  logic [3:0] exec_opcode,
    input  logic       completed_data,
    output mem_state_t mem_state
);

    mem_state_t r_state;
    mem_state_t w_next;

    // State register, forced to IDLE asynchronously on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= MS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: launch from IDLE, advance only on completed_data.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MS_IDLE: begin
                if (enable_execute && is_load(exec_opcode)) begin
                    w_next = (exec_opcode == OP_LDI) ? MS_IND_READ : MS_READ;
                end else if (enable_execute && is_store(exec_opcode)) begin
                    w_next = (exec_opcode == OP_STI) ? MS_IND_READ : MS_WRITE;
                end else begin
                    w_next = MS_IDLE;
                end
            end
            MS_IND_READ: begin
                if (completed_data) begin
                    case (exec_opcode)
                        OP_LDI:  w_next = MS_READ;
                        OP_STI:  w_next = MS_WRITE;
                        default: w_next = MS_IDLE;
                    endcase
                end else begin
                    w_next = MS_IND_READ;
                end
            end
            MS_READ, MS_WRITE: begin
                if (completed_data) begin
                    w_next = MS_IDLE;
                end else begin
                    w_next = r_state;
                end
            end
            default: w_next = MS_IDLE;
        endcase
    end

    // Output decode: the state itself is the registered output.
    always_comb begin
        mem_state = r_state;
    end

endmodule

// File: rtl/lc3_control_unit.sv
// LC-3 pipeline controller: pipeline fill, memory and control-flow stalls,
// ALU operand forwarding and the branch decision.
module lc3_control_unit
    import lc3_ctrl_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    lc3_control_unit_if.slave bus
);

    logic [3:0] r_fill;
    logic       r_ctl_stall;
    logic       r_wb_alu;

    mem_state_t w_mem_state;
    logic       w_mem_stall;
    logic       w_ctl_release;
    logic       w_read_done;
    logic       w_fetch;
    logic       w_update_pc;
    logic       w_decode;
    logic       w_execute;
    logic [3:0] w_op_ir;
    logic [3:0] w_op_ex;
    logic [3:0] w_op_fetch;

    assign w_op_ir    = bus.IR[15:12];
    assign w_op_ex    = bus.IR_EXEC[15:12];
    assign w_op_fetch = bus.Imem_dout[15:12];

    lc3_mem_fsm u_mem_fsm (
        .clock          (clock),
        .reset          (reset),
        .enable_execute (w_execute),
        .exec_opcode    (w_op_ex),
        .completed_data (bus.completed_data),
        .mem_state      (w_mem_state)
    );

    // Stage enables: memory accesses freeze the front end; a pending
    // BR/JMP freezes only fetch and PC update until it resolves.
    always_comb begin
        w_mem_stall   = (w_mem_state != MS_IDLE);
        w_read_done   = (w_mem_state == MS_READ) & bus.completed_data;
        w_ctl_release = r_ctl_stall & bus.completed_instr & is_ctl(w_op_ex) & ~w_mem_stall;
        if (w_mem_stall) begin
            w_fetch     = 1'b0;
            w_update_pc = 1'b0;
            w_decode    = 1'b0;
            w_execute   = 1'b0;
        end else begin
            w_fetch     = r_fill[0] & ~r_ctl_stall;
            w_update_pc = r_fill[0] & (~r_ctl_stall | w_ctl_release);
            w_decode    = r_fill[1];
            w_execute   = r_fill[2];
        end
    end

    // Fill shifter, control-stall flag and delayed ALU writeback strobe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_fill      <= 4'b0000;
            r_ctl_stall <= 1'b0;
            r_wb_alu    <= 1'b0;
        end else begin
            r_fill   <= {r_fill[2:0], 1'b1};
            r_wb_alu <= w_execute & is_alu(w_op_ex);
            if (w_fetch && is_ctl(w_op_fetch)) begin
                r_ctl_stall <= 1'b1;
            end else if (w_ctl_release) begin
                r_ctl_stall <= 1'b0;
            end else begin
                r_ctl_stall <= r_ctl_stall;
            end
        end
    end

    // Output drive; the combinational branch/bypass terms are held low in reset.
    always_comb begin
        bus.enable_fetch     = w_fetch;
        bus.enable_updatePC  = w_update_pc;
        bus.enable_decode    = w_decode;
        bus.enable_execute   = w_execute;
        bus.enable_writeback = r_wb_alu | w_read_done;
        bus.mem_state        = w_mem_state;
        if (!reset) begin
            bus.br_taken     = 1'b0;
            bus.bypass_alu_1 = 1'b0;
            bus.bypass_alu_2 = 1'b0;
        end else begin
            bus.br_taken = bus.completed_instr &
                           ((w_op_ex == OP_JMP) |
                            ((w_op_ex == OP_BR) & (|(bus.NZP & bus.PSR))));
            if (is_alu(w_op_ex)) begin
                bus.bypass_alu_1 = (bus.IR_EXEC[11:9] == bus.IR[8:6]) & uses_sr1(w_op_ir);
                bus.bypass_alu_2 = (bus.IR_EXEC[11:9] == bus.IR[2:0]) &
                                   ((w_op_ir == OP_ADD) | (w_op_ir == OP_AND)) & ~bus.IR[5];
            end else begin
                bus.bypass_alu_1 = 1'b0;
                bus.bypass_alu_2 = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lc3_control_unit.sv
// Self-checking bench for lc3_control_unit: directed scenarios plus a
// randomized run, all compared against a cycle-level behavioural model.
module tb_lc3_control_unit;

    logic clock = 1'b0;
    logic reset;

    lc3_control_unit_if bus();

    lc3_control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edges since reset release, pending memory phases
    // (0=read, 1=pointer read, 2=write), ALU writeback due, waiting on BR/JMP.
    int   cyc;
    int   phases[$];
    logic wb_pending;
    logic ctl_wait;

    int ldi_seq[5] = '{1, 1, 0, 0, 3};
    logic ldi_cd[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    localparam logic [15:0] ADD_NOP = 16'h1042;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic m_alu(input logic [3:0] op);
        return op inside {4'h1, 4'h5, 4'h9, 4'hE};
    endfunction

    function automatic logic m_ctl(input logic [3:0] op);
        return op inside {4'h0, 4'hC};
    endfunction

    task automatic model_reset();
        cyc = 0;
        phases.delete();
        wb_pending = 1'b0;
        ctl_wait   = 1'b0;
    endtask

    task automatic drive(input logic [15:0] ir, input logic [15:0] irx, input logic [15:0] im,
                         input logic [2:0] nzp, input logic [2:0] psr,
                         input logic ci, input logic cd);
        bus.IR              = ir;
        bus.IR_EXEC         = irx;
        bus.Imem_dout       = im;
        bus.NZP             = nzp;
        bus.PSR             = psr;
        bus.completed_instr = ci;
        bus.completed_data  = cd;
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_upc"}, 16'(bus.enable_updatePC), 16'd0);
        check_val({tag, "_fetch"}, 16'(bus.enable_fetch), 16'd0);
        check_val({tag, "_dec"}, 16'(bus.enable_decode), 16'd0);
        check_val({tag, "_exe"}, 16'(bus.enable_execute), 16'd0);
        check_val({tag, "_wb"}, 16'(bus.enable_writeback), 16'd0);
        check_val({tag, "_br"}, 16'(bus.br_taken), 16'd0);
        check_val({tag, "_byp"}, 16'({bus.bypass_alu_1, bus.bypass_alu_2}), 16'd0);
        check_val({tag, "_mem"}, 16'(bus.mem_state), 16'd3);
    endtask

    // Compare every output against the model for the current inputs, then
    // advance the model across the coming rising edge.
    task automatic run_cycle();
        logic [3:0]  xo, io, fo;
        logic        stall, rel, e_fetch, e_upc, e_dec, e_exe, e_wb, e_br, e_b1, e_b2;
        logic [15:0] e_mem;
        xo = bus.IR_EXEC[15:12];
        io = bus.IR[15:12];
        fo = bus.Imem_dout[15:12];
        stall   = (phases.size() != 0);
        e_mem   = stall ? 16'(phases[0]) : 16'd3;
        rel     = ctl_wait && bus.completed_instr && m_ctl(xo) && !stall;
        e_fetch = (cyc >= 1) && !stall && !ctl_wait;
        e_upc   = (cyc >= 1) && !stall && (!ctl_wait || rel);
        e_dec   = (cyc >= 2) && !stall;
        e_exe   = (cyc >= 3) && !stall;
        e_wb    = wb_pending || ((e_mem == 16'd0) && bus.completed_data);
        e_br    = bus.completed_instr &&
                  ((xo == 4'hC) || ((xo == 4'h0) && ((bus.NZP & bus.PSR) != 3'b000)));
        e_b1    = m_alu(xo) && (bus.IR_EXEC[11:9] == bus.IR[8:6]) &&
                  (io inside {4'h1, 4'h5, 4'h9, 4'h6, 4'h7, 4'hC});
        e_b2    = m_alu(xo) && (bus.IR_EXEC[11:9] == bus.IR[2:0]) &&
                  (io inside {4'h1, 4'h5}) && !bus.IR[5];

        check_val("upc", 16'(bus.enable_updatePC), 16'(e_upc));
        check_val("fetch", 16'(bus.enable_fetch), 16'(e_fetch));
        check_val("decode", 16'(bus.enable_decode), 16'(e_dec));
        check_val("execute", 16'(bus.enable_execute), 16'(e_exe));
        check_val("writeback", 16'(bus.enable_writeback), 16'(e_wb));
        check_val("br_taken", 16'(bus.br_taken), 16'(e_br));
        check_val("bypass1", 16'(bus.bypass_alu_1), 16'(e_b1));
        check_val("bypass2", 16'(bus.bypass_alu_2), 16'(e_b2));
        check_val("mem_state", 16'(bus.mem_state), e_mem);

        if (stall) begin
            if (bus.completed_data) void'(phases.pop_front());
        end else if (e_exe) begin
            case (xo)
                4'h2, 4'h6: phases.push_back(0);
                4'hA: begin phases.push_back(1); phases.push_back(0); end
                4'hB: begin phases.push_back(1); phases.push_back(2); end
                4'h3, 4'h7: phases.push_back(2);
                default: ;
            endcase
        end
        wb_pending = e_exe && m_alu(xo);
        if (e_fetch && m_ctl(fo)) ctl_wait = 1'b1;
        else if (rel) ctl_wait = 1'b0;
        if (cyc < 8) cyc++;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [15:0] x;
        reset = 1'b0;
        model_reset();
        drive(ADD_NOP, ADD_NOP, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("rst");

        // Refill after release with an ADD stream.
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(ADD_NOP, ADD_NOP, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
            check_val("fill_fetch", 16'(bus.enable_fetch), 16'(k >= 1));
            check_val("fill_exe", 16'(bus.enable_execute), 16'(k >= 3));
            check_val("fill_wb", 16'(bus.enable_writeback), 16'(k >= 4));
            run_cycle();
        end

        // LDI with completed_data pulses two cycles apart.
        drive(ADD_NOP, 16'hA200, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        run_cycle();
        for (int k = 0; k < 5; k++) begin
            drive(ADD_NOP, (k == 4) ? ADD_NOP : 16'hA200, ADD_NOP, 3'b000, 3'b000, 1'b0, ldi_cd[k]);
            check_val("ldi_mem", 16'(bus.mem_state), 16'(ldi_seq[k]));
            if (k < 4) check_val("ldi_fetch", 16'(bus.enable_fetch), 16'd0);
            if (k == 3) check_val("ldi_wb", 16'(bus.enable_writeback), 16'd1);
            run_cycle();
        end

        // Branch fetched, stalled, then resolved in execute.
        drive(ADD_NOP, ADD_NOP, 16'h0405, 3'b000, 3'b000, 1'b0, 1'b0);
        run_cycle();
        drive(ADD_NOP, ADD_NOP, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        check_val("ctl_fetch", 16'(bus.enable_fetch), 16'd0);
        check_val("ctl_upc", 16'(bus.enable_updatePC), 16'd0);
        run_cycle();
        drive(ADD_NOP, 16'h0405, ADD_NOP, 3'b010, 3'b010, 1'b1, 1'b0);
        check_val("br_take", 16'(bus.br_taken), 16'd1);
        check_val("br_upc", 16'(bus.enable_updatePC), 16'd1);
        run_cycle();
        drive(ADD_NOP, 16'h0405, ADD_NOP, 3'b010, 3'b001, 1'b1, 1'b0);
        check_val("br_not", 16'(bus.br_taken), 16'd0);
        check_val("br_refetch", 16'(bus.enable_fetch), 16'd1);
        run_cycle();

        // Forwarding cases.
        drive(16'h1201, 16'h1042, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        check_val("byp_a1", 16'(bus.bypass_alu_1), 16'd1);
        check_val("byp_a2", 16'(bus.bypass_alu_2), 16'd0);
        run_cycle();
        drive(16'h1220, 16'h1042, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        check_val("byp_imm2", 16'(bus.bypass_alu_2), 16'd0);
        run_cycle();
        drive(16'h1000, 16'h1042, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        check_val("byp_reg2", 16'(bus.bypass_alu_2), 16'd1);
        run_cycle();

        // Reset asserted while a store is in WRITE.
        drive(ADD_NOP, 16'h3000, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        run_cycle();
        drive(ADD_NOP, 16'h3000, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
        check_val("st_mem", 16'(bus.mem_state), 16'd2);
        bus.IR_EXEC = 16'hC000;
        bus.completed_instr = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clock);
        #1;
        check_all_zero("held_rst");
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(ADD_NOP, ADD_NOP, ADD_NOP, 3'b000, 3'b000, 1'b0, 1'b0);
            check_val("refill_fetch", 16'(bus.enable_fetch), 16'(k >= 1));
            check_val("refill_dec", 16'(bus.enable_decode), 16'(k >= 2));
            run_cycle();
        end

        // Randomized traffic; IR_EXEC is held while a memory access is pending.
        x = ADD_NOP;
        for (int n = 0; n < 600; n++) begin
            if (phases.size() == 0) x = 16'($urandom);
            drive(16'($urandom), x, 16'($urandom), 3'($urandom), 3'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3_control_unit.md
# lc3_control_unit

Pipeline controller for the LC-3 core and the consuming end of the `control_in` bus. It samples the instruction-stream and status signals (`IR`, `IR_EXEC`, `Imem_dout`, `NZP`, `PSR`, `completed_instr`, `completed_data`) and drives the stage enables, ALU bypass selects, the branch decision and the data-memory state. It sits between fetch/decode/execute/writeback and the data memory port, and is the DUT-side counterpart of the `control_in` responder agent.

## Interface
No parameters. Widths are fixed by the ISA.
- `clock`  in  1  single clock; all flops on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `completed_instr`  in  1  execute stage finished its instruction this cycle
- `completed_data`  in  1  data memory access finished this cycle
- `IR`  in  16  instruction in decode
- `IR_EXEC`  in  16  instruction in execute
- `Imem_dout`  in  16  instruction being fetched
- `NZP`  in  3  branch condition field of the executing BR
- `PSR`  in  3  current condition codes {N,Z,P}
- `enable_updatePC`, `enable_fetch`, `enable_decode`, `enable_execute`, `enable_writeback`  out  1 each  stage enables
- `bypass_alu_1`, `bypass_alu_2`  out  1 each  forward execute result to ALU operand 1/2
- `br_taken`  out  1  load the branch/JMP target into the PC
- `mem_state`  out  2  0=READ, 1=IND_READ, 2=WRITE, 3=IDLE

## Operation
- Opcode field is `[15:12]`. ALU class = ADD 0001, AND 0101, NOT 1001, LEA 1110. Load = LD 0010, LDR 0110, LDI 1010. Store = ST 0011, STR 0111, STI 1011. Control = BR 0000, JMP 1100.
- **Pipeline fill:** a 4-bit valid shift register `fill`, reset to 0, shifts in 1 every cycle.
  - `enable_fetch` and `enable_updatePC` become 1 in the first cycle after reset release.
  - decode, execute and writeback follow at +1, +2 and +3 cycles.
- **Memory FSM** (registered `mem_state`, reset value 3=IDLE):
  - From IDLE, when `enable_execute`=1: LD/LDR go to READ; LDI/STI go to IND_READ; ST/STR go to WRITE.
  - From IND_READ with `completed_data`=1: LDI goes to READ, STI goes to WRITE.
  - From READ or WRITE with `completed_data`=1: go to IDLE.
  - With `completed_data`=0, the FSM holds its current state indefinitely.
- **Memory stall:** while `mem_state`≠3, `enable_updatePC`, `enable_fetch`, `enable_decode` and `enable_execute` are 0.
- **Writeback enable:** `enable_writeback` is 1 in these cases only:
  - the cycle after an ALU-class instruction executes (registered);
  - the cycle in which READ completes.
  - It is 0 for stores and control instructions.
- **Control stall:**
  - Flag `ctl_stall` sets at the clock edge where `enable_fetch`=1 and `Imem_dout` is BR or JMP.
  - While it is set, `enable_fetch`=`enable_updatePC`=0; decode and execute continue.
  - It clears in the cycle where `completed_instr`=1 and `IR_EXEC` is BR or JMP. In that same cycle `enable_updatePC`=1.
- **Branch decision:** `br_taken` = `completed_instr` & ((`IR_EXEC` is JMP) | (`IR_EXEC` is BR & |(`NZP` & `PSR`))). This is combinational.
- **Bypass** (combinational; applies only when `IR_EXEC` is ALU class):
  - `bypass_alu_1` = `IR_EXEC[11:9]`==`IR[8:6]` and `IR` is ADD, AND, NOT, LDR, STR or JMP.
  - `bypass_alu_2` = `IR_EXEC[11:9]`==`IR[2:0]` and `IR` is ADD/AND with `IR[5]`=0.
- **Simultaneous events:**
  - A memory stall overrides the control-stall release; the release is deferred until `mem_state`=3.
  - Reset asserted mid-transaction forces IDLE, clears `fill` and `ctl_stall`, and zeroes all outputs immediately.

## Timing
- Reset values: every enable, bypass and `br_taken` is 0; `mem_state`=3.
- FSM outputs change only on rising `clock` edges; `reset` acts asynchronously.
- Memory stall latency: enables drop in the cycle after `enable_execute` sees a memory op. They reassert the cycle after the final `completed_data`.
- Minimum access length is LD/ST = 1 cycle and LDI/STI = 2 cycles, plus any cycles spent waiting on `completed_data`.
- Bypass and `br_taken` are same-cycle combinational, with no flop.

## Structure
- Package `lc3_ctrl_pkg` holds:
  - the opcode localparams and the ALU/load/store/control class functions;
  - the `mem_state_t` enum: READ=0, IND_READ=1, WRITE=2, IDLE=3.
- Sub-module `lc3_mem_fsm` holds the memory FSM. Its inputs are `clock`, `reset`, `enable_execute`, `IR_EXEC[15:12]` and `completed_data`; its output is `mem_state`. The top level holds the fill, stall, bypass and branch logic.

## Test plan
- Reset release with NOP-like ADD stream: fetch/updatePC=1 at cycle 1, decode at 2, execute at 3, writeback at 4; `mem_state` stays 3.
- LDI (`IR_EXEC`=16'hA200) with `completed_data` pulses 2 cycles apart: `mem_state` goes 1, 1, 0, 0, 3; enables are low throughout; `enable_writeback`=1 on the final READ completion.
- BR (`IR_EXEC`=16'h0405, `NZP`=3'b010):
  - with `PSR`=3'b010 and `completed_instr`=1, `br_taken`=1 and `enable_updatePC`=1, and `ctl_stall` clears;
  - with `PSR`=3'b001, `br_taken`=0.
- `IR_EXEC`=16'h1042 (ADD R0,R1,R2), `IR`=16'h1201 (ADD R1,R0,R1): `bypass_alu_1`=1, `bypass_alu_2`=0. With `IR`=16'h1220, `bypass_alu_2`=0 because of the immediate.
- Reset asserted during WRITE: `mem_state`=3 and all outputs 0 without waiting for a clock edge; the refill sequence repeats after release.
